// File: rtl/t07_mmio_responder_if.sv
// ---------------------------------------------------------------------------
// t07_mmio_responder_if
//   Bus bundle between the team 07 memory handler and its MMIO responder
//   (rwi/busy protocol).
//
//   Handler -> responder:
//     rwi_i   [1:0]  request code: 00 idle, 01 write, 10 read, 11 fetch
//     addr_i  [31:0] byte address (bits [1:0] ignored by the responder)
//     data_i  [31:0] write data
//   Responder -> handler:
//     busy_o         high while a transaction is in service
//     data_o  [31:0] result of the last read
//     instr_o [31:0] result of the last fetch
//     err_o          one-cycle pulse when an access is rejected
//
//   Modports: master = handler side, slave = responder side.
// ---------------------------------------------------------------------------
interface t07_mmio_responder_if;
  logic [1:0]  rwi_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        busy_o;
  logic [31:0] data_o;
  logic [31:0] instr_o;
  logic        err_o;

  modport master (
    output rwi_i, addr_i, data_i,
    input  busy_o, data_o, instr_o, err_o
  );

  modport slave (
    input  rwi_i, addr_i, data_i,
    output busy_o, data_o, instr_o, err_o
  );
endinterface

// File: rtl/t07_mmio_responder.sv
// ---------------------------------------------------------------------------
// t07_mmio_responder
//   Memory-side responder for the team 07 memory handler. A request seen in
//   IDLE is latched, busy_o is held high for LATENCY cycles, and the access
//   is performed on the last busy edge so the result is valid in the single
//   DONE cycle where busy_o falls. Backing store is a word-addressed RAM.
//
//   Parameters:
//     DEPTH_WORDS  words of backing RAM (power of two)
//     LATENCY      cycles busy_o stays high per transaction (1..15)
//     ROM_WORDS    low word indices treated as program ROM (protect build)
//
//   Ports:
//     clk          system clock, rising edge
//     rst          synchronous active-high reset (RAM contents preserved)
//     bus          t07_mmio_responder_if.slave: rwi_i/addr_i/data_i in,
//                  busy_o/data_o/instr_o/err_o out (all registered)
//
//   Build option:
//     T07_MMIO_ROM_PROTECT_EN  when defined, writes to word indices below
//                              ROM_WORDS are dropped and flagged on err_o.
// ---------------------------------------------------------------------------
module t07_mmio_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int ROM_WORDS   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  t07_mmio_responder_if.slave  bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_FETCH = 2'b11;

  localparam logic [3:0]  LAT_LAST = 4'(LATENCY - 1);
  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);
  localparam logic [31:0] OOR_DATA  = 32'hDEADBEEF;

  // FSM and latched request
  logic [1:0]  state_q, state_d;
  logic [3:0]  lat_ct_q, lat_ct_d;
  logic [1:0]  op_q;
  logic [29:0] idx_q;
  logic [31:0] wdata_q;

  // Registered outputs
  logic        busy_q;
  logic        err_q;
  logic [31:0] data_q;
  logic [31:0] instr_q;

  // Backing RAM
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          commit;
  logic          oor;
  logic          rom_hit;
  logic          wr_en;
  logic          reject;
  logic [AW-1:0] ram_idx;

  assign accept  = (state_q == S_IDLE) && (bus.rwi_i != 2'b00);
  // The access happens on the edge that leaves the last BUSY cycle.
  assign commit  = (state_q == S_BUSY) && (lat_ct_q == LAT_LAST);
  assign oor     = (idx_q >= DEPTH_IDX);
  assign ram_idx = idx_q[AW-1:0];

`ifdef T07_MMIO_ROM_PROTECT_EN
  assign rom_hit = (op_q == OP_WRITE) && (idx_q < 30'(ROM_WORDS));
`else
  // Guard compiled out; the term is constant zero.
  assign rom_hit = 1'b0 & (idx_q < 30'(ROM_WORDS));
`endif

  assign reject = oor || rom_hit;

  // Reset during the final BUSY cycle wins over the commit.
  assign wr_en = commit && !rst && (op_q == OP_WRITE) && !reject;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    lat_ct_d = lat_ct_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_BUSY;
          lat_ct_d = 4'd0;
        end
      end
      S_BUSY: begin
        lat_ct_d = lat_ct_q + 4'd1;
        if (commit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        lat_ct_d = 4'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lat_ct_q <= 4'd0;
      op_q     <= 2'b00;
      idx_q    <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      lat_ct_q <= lat_ct_d;
      // busy_o is the registered image of the next state, so it is high
      // exactly while the FSM sits in BUSY.
      busy_q   <= (state_d == S_BUSY);
      err_q    <= commit && reject;

      if (accept) begin
        op_q    <= bus.rwi_i;
        idx_q   <= bus.addr_i[31:2];
        wdata_q <= bus.data_i;
      end

      if (commit && (op_q == OP_READ)) begin
        data_q <= oor ? OOR_DATA : mem[ram_idx];
      end
      if (commit && (op_q == OP_FETCH)) begin
        instr_q <= oor ? OOR_DATA : mem[ram_idx];
      end
    end
  end

  // RAM write port kept in its own block without reset so it maps onto
  // block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ram_idx] <= wdata_q;
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.err_o   = err_q;
  assign bus.data_o  = data_q;
  assign bus.instr_o = instr_q;

endmodule

// File: tb/tb_t07_mmio_responder.sv
module tb_t07_mmio_responder;

  localparam int L     = 2;
  localparam int DEPTH = 256;
  localparam int ROMW  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  t07_mmio_responder_if bus ();

  t07_mmio_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (L),
    .ROM_WORDS   (ROMW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Transaction-level model: an accepted request at cycle T shows busy for
  // cycles T+1..T+L, completes with its results visible in T+L+1, and the
  // responder can accept again from T+L+2.
  // -------------------------------------------------------------------------
  logic [31:0] mmem [int];
  logic        exp_busy  = 1'b0;
  logic        exp_err   = 1'b0;
  logic [31:0] exp_data  = '0;
  logic [31:0] exp_instr = '0;

  initial begin
    int          cyc;
    int          free_at;
    bit          pend;
    int          pend_t;
    logic [1:0]  pend_op;
    int          pend_idx;
    logic [31:0] pend_wd;
    bit          is_oor;
    bit          is_rom;
    logic [31:0] rd;
    cyc = 0; free_at = 0; pend = 0; pend_t = 0; pend_op = 0; pend_idx = 0; pend_wd = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        pend      = 0;
        exp_busy  = 0;
        exp_err   = 0;
        exp_data  = '0;
        exp_instr = '0;
        free_at   = cyc + 1;
      end else begin
        exp_err = 0;
        if (pend && cyc == pend_t + L) begin
          is_oor = (pend_idx >= DEPTH);
`ifdef T07_MMIO_ROM_PROTECT_EN
          is_rom = (pend_op == 2'b01) && (pend_idx < ROMW);
`else
          is_rom = 0;
`endif
          rd = 32'hDEADBEEF;
          if (!is_oor) rd = mmem.exists(pend_idx) ? mmem[pend_idx] : 32'hxxxxxxxx;
          case (pend_op)
            2'b01: if (!is_oor && !is_rom) mmem[pend_idx] = pend_wd;
            2'b10: exp_data  = rd;
            2'b11: exp_instr = rd;
            default: ;
          endcase
          exp_err = is_oor || is_rom;
          pend = 0;
        end
        if (!pend && cyc >= free_at && bus.rwi_i != 2'b00) begin
          pend     = 1;
          pend_t   = cyc;
          pend_op  = bus.rwi_i;
          pend_idx = int'(bus.addr_i[31:2]);
          pend_wd  = bus.data_i;
          free_at  = cyc + L + 2;
        end
        exp_busy = pend && (cyc + 1 <= pend_t + L);
      end
      cyc++;
    end
  end

  // One compare process against the model on every cycle after reset.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("model_busy",  {31'd0, bus.busy_o}, {31'd0, exp_busy});
        chk("model_err",   {31'd0, bus.err_o},  {31'd0, exp_err});
        chk("model_data",  bus.data_o,  exp_data);
        chk("model_instr", bus.instr_o, exp_instr);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Directed stimulus
  // -------------------------------------------------------------------------
  // Issues one single-cycle request and returns at the DONE negedge.
  task automatic xact(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                      output int bc, output bit ok);
    bit seen;
    @(negedge clk);
    bus.rwi_i  = op;
    bus.addr_i = a;
    bus.data_i = d;
    bc = 0; ok = 0; seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      bus.rwi_i = 2'b00;
      if (bus.busy_o === 1'b1) begin
        bc++;
        seen = 1;
      end else if (seen) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL done_timeout: got no busy fall want fall within 30 cycles (op=%b addr=%h)", op, a);
    end
    $display("xact op=%b addr=%h wdata=%h busy_cycles=%0d data=%h instr=%h err=%b",
             op, a, d, bc, bus.data_o, bus.instr_o, bus.err_o);
  endtask

  initial begin
    int          bc;
    bit          ok;
    logic [11:0] pat;
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int          bc;
    bit          ok;
    logic [11:0] pat;
    bus.rwi_i  = 2'b00;
    bus.addr_i = '0;
    bus.data_i = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'd0, bus.busy_o}, 32'd0);
    chk("rst_data",  bus.data_o,  32'd0);
    chk("rst_instr", bus.instr_o, 32'd0);
    chk("rst_err",   {31'd0, bus.err_o}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Preload word 4, then reset again (RAM survives reset) and fetch it.
    xact(2'b01, 32'h0000_0010, 32'h0050_0093, bc, ok);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xact(2'b11, 32'h0000_0010, 32'h0, bc, ok);
    chk("fetch_busy_cycles", 32'(bc), 32'd2);
    chk("fetch_instr", bus.instr_o, 32'h0050_0093);
    chk("fetch_data_untouched", bus.data_o, 32'd0);

    // Write then read back.
    xact(2'b01, 32'h0000_0104, 32'hCAFE_F00D, bc, ok);
    chk("wr104_err", {31'd0, bus.err_o}, 32'd0);
    xact(2'b10, 32'h0000_0104, 32'h0, bc, ok);
    chk("rd104_data", bus.data_o, 32'hCAFE_F00D);
    chk("rd104_err", {31'd0, bus.err_o}, 32'd0);
    chk("rd104_instr_held", bus.instr_o, 32'h0050_0093);

    // Held read: busy pattern 0,1,1,0 repeating.
    @(negedge clk);
    pat = 12'b0110_0110_0110;
    bus.rwi_i  = 2'b10;
    bus.addr_i = 32'h0000_0104;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("held_busy_%0d", k), {31'd0, bus.busy_o}, {31'd0, pat[11-k]});
      @(negedge clk);
    end
    bus.rwi_i = 2'b00;
    $display("xact held read addr=00000104 cycles=12 data=%h", bus.data_o);
    repeat (2) @(negedge clk);
    chk("held_idle_after", {31'd0, bus.busy_o}, 32'd0);

    // Out of range: index 256 aliases RAM word 0 in the low bits.
    xact(2'b01, 32'h0000_0000, 32'hA5A5_A5A5, bc, ok);
    xact(2'b10, 32'h0000_0400, 32'h0, bc, ok);
    chk("oor_rd_data", bus.data_o, 32'hDEAD_BEEF);
    chk("oor_rd_err",  {31'd0, bus.err_o}, 32'd1);
    @(negedge clk);
    chk("oor_err_pulse_end", {31'd0, bus.err_o}, 32'd0);
    xact(2'b01, 32'h0000_0400, 32'h1111_1111, bc, ok);
    chk("oor_wr_err", {31'd0, bus.err_o}, 32'd1);
    xact(2'b10, 32'h0000_0000, 32'h0, bc, ok);
    chk("oor_wr_dropped", bus.data_o, 32'hA5A5_A5A5);
    xact(2'b11, 32'h0000_0800, 32'h0, bc, ok);
    chk("oor_fetch_instr", bus.instr_o, 32'hDEAD_BEEF);

    // Reset in the final BUSY cycle cancels the write.
    xact(2'b01, 32'h0000_0020, 32'h0BAD_F00D, bc, ok);
    @(negedge clk);
    bus.rwi_i  = 2'b01;
    bus.addr_i = 32'h0000_0020;
    bus.data_i = 32'h1234_5678;
    @(negedge clk);
    bus.rwi_i = 2'b00;
    @(negedge clk);
    chk("midrst_last_busy", {31'd0, bus.busy_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy_drop", {31'd0, bus.busy_o}, 32'd0);
    rst = 1'b0;
    $display("xact write addr=00000020 wdata=12345678 cancelled by reset");
    xact(2'b10, 32'h0000_0020, 32'h0, bc, ok);
    chk("midrst_old_value", bus.data_o, 32'h0BAD_F00D);

`ifdef T07_MMIO_ROM_PROTECT_EN
    xact(2'b01, 32'h0000_0000, 32'hFFFF_FFFF, bc, ok);
    chk("rom_wr_err", {31'd0, bus.err_o}, 32'd1);
    xact(2'b01, 32'h0000_0100, 32'h5A5A_5A5A, bc, ok);
    chk("rom_edge_wr_err", {31'd0, bus.err_o}, 32'd0);
    xact(2'b10, 32'h0000_0100, 32'h0, bc, ok);
    chk("rom_edge_commit", bus.data_o, 32'h5A5A_5A5A);
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
